// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reorder_buffer_pkg : shared ROB sizing and common-data-bus field positions
// Revision: 1.0
// ----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int CDB_W     = 148;
    localparam int DATA_W    = 32;
    localparam int FLAGS_W   = 4;
    localparam int DEST_W    = 4;
    localparam int COUNT_W   = 4;

    localparam int CDB_VALID_BIT  = 147;
    localparam int CDB_TAG_MSB    = 146;
    localparam int CDB_TAG_LSB    = 144;
    localparam int CDB_RESULT_MSB = 143;
    localparam int CDB_RESULT_LSB = 112;
    localparam int CDB_FLAGS_MSB  = 111;
    localparam int CDB_FLAGS_LSB  = 108;

    localparam logic [COUNT_W-1:0] ROB_FULL_COUNT = 4'd8;

    typedef logic [TAG_W-1:0] rob_tag_t;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reorder_buffer : 8-entry circular ROB, CDB completion, in-order retirement
// Revision: 1.0
// ----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    input  logic               append,
    input  logic               S,
    input  logic [DEST_W-1:0]  AppendDest,
    input  logic               Flush,
    input  logic [CDB_W-1:0]   CDB,
    input  logic [TAG_W-1:0]   QueryTag,
    output logic [TAG_W-1:0]   ROBTail,
    output logic               Full,
    output logic               QueryDone,
    output logic [DATA_W-1:0]  QueryValue,
    output logic               CommitValid,
    output logic [DEST_W-1:0]  CommitDest,
    output logic [DATA_W-1:0]  CommitValue,
    output logic [FLAGS_W-1:0] CommitFlags,
    output logic               CommitS
);

    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_s;
    logic [DEST_W-1:0]    r_dest  [ROB_DEPTH];
    logic [DATA_W-1:0]    r_value [ROB_DEPTH];
    logic [FLAGS_W-1:0]   r_flags [ROB_DEPTH];
    rob_tag_t             r_head;
    rob_tag_t             r_tail;
    logic [COUNT_W-1:0]   r_count;

    logic                 w_cdb_valid;
    rob_tag_t             w_cdb_tag;
    logic [DATA_W-1:0]    w_cdb_result;
    logic [FLAGS_W-1:0]   w_cdb_flags;
    logic                 w_cdb_unused;
    logic                 w_retire;
    logic                 w_accept;
    logic                 w_cdb_hit;
    logic                 w_query_bypass;

    assign w_cdb_valid  = CDB[CDB_VALID_BIT];
    assign w_cdb_tag    = CDB[CDB_TAG_MSB:CDB_TAG_LSB];
    assign w_cdb_result = CDB[CDB_RESULT_MSB:CDB_RESULT_LSB];
    assign w_cdb_flags  = CDB[CDB_FLAGS_MSB:CDB_FLAGS_LSB];
    assign w_cdb_unused = ^CDB[CDB_FLAGS_LSB-1:0];

    // Acceptance looks at the pre-retirement count, so a full ROB never reuses a slot in the same edge.
    assign w_retire  = (r_count != '0) && r_done[r_head];
    assign w_accept  = append && (r_count != ROB_FULL_COUNT);
    // A result landing on the head entry must not be re-marked done while that slot is being freed.
    assign w_cdb_hit = w_cdb_valid && r_busy[w_cdb_tag] && !(w_retire && (w_cdb_tag == r_head));

    assign ROBTail = r_tail;
    assign Full    = (r_count == ROB_FULL_COUNT);

    assign w_query_bypass = w_cdb_valid && (w_cdb_tag == QueryTag) && r_busy[QueryTag];
    assign QueryDone      = w_query_bypass || r_done[QueryTag];
    assign QueryValue     = w_query_bypass   ? w_cdb_result :
                            r_done[QueryTag] ? r_value[QueryTag] : '0;

    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            r_busy      <= '0;
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            CommitValid <= 1'b0;
            if (Reset) begin
                CommitDest  <= '0;
                CommitValue <= '0;
                CommitFlags <= '0;
                CommitS     <= 1'b0;
            end
        end else begin
            CommitValid <= w_retire;
            if (w_retire) begin
                CommitDest     <= r_dest[r_head];
                CommitValue    <= r_value[r_head];
                CommitFlags    <= r_flags[r_head];
                CommitS        <= r_s[r_head];
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
            end
            if (w_cdb_hit) begin
                r_done[w_cdb_tag]  <= 1'b1;
                r_value[w_cdb_tag] <= w_cdb_result;
                r_flags[w_cdb_tag] <= w_cdb_flags;
            end
            if (w_accept) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_s[r_tail]    <= S;
                r_dest[r_tail] <= AppendDest;
                r_tail         <= r_tail + 1'b1;
            end
            r_count <= r_count + {{(COUNT_W-1){1'b0}}, w_accept}
                               - {{(COUNT_W-1){1'b0}}, w_retire};
        end
    end

endmodule : reorder_buffer
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reorder_buffer : directed self-checking bench for reorder_buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_reorder_buffer;

    logic           CLK;
    logic           Reset;
    logic           append;
    logic           S;
    logic [3:0]     AppendDest;
    logic           Flush;
    logic [147:0]   CDB;
    logic [2:0]     QueryTag;
    logic [2:0]     ROBTail;
    logic           Full;
    logic           QueryDone;
    logic [31:0]    QueryValue;
    logic           CommitValid;
    logic [3:0]     CommitDest;
    logic [31:0]    CommitValue;
    logic [3:0]     CommitFlags;
    logic           CommitS;

    int n_checks;
    int n_fails;

    reorder_buffer dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .append      (append),
        .S           (S),
        .AppendDest  (AppendDest),
        .Flush       (Flush),
        .CDB         (CDB),
        .QueryTag    (QueryTag),
        .ROBTail     (ROBTail),
        .Full        (Full),
        .QueryDone   (QueryDone),
        .QueryValue  (QueryValue),
        .CommitValid (CommitValid),
        .CommitDest  (CommitDest),
        .CommitValue (CommitValue),
        .CommitFlags (CommitFlags),
        .CommitS     (CommitS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cdb(input logic v, input logic [2:0] tag, input logic [31:0] val,
                           input logic [3:0] fl);
        logic [107:0] junk;
        junk = {4{27'h5a5a5a5}};
        CDB = {v, tag, val, fl, junk};
        #1;
    endtask

    task automatic set_app(input logic a, input logic s, input logic [3:0] d);
        append     = a;
        S          = s;
        AppendDest = d;
        #1;
    endtask

    task automatic check_commit(input string tag, input logic [3:0] d, input logic [31:0] v,
                                input logic [3:0] f, input logic s);
        check({tag, "_valid"}, {31'b0, CommitValid}, 32'd1);
        check({tag, "_dest"},  {28'b0, CommitDest},  {28'b0, d});
        check({tag, "_value"}, CommitValue, v);
        check({tag, "_flags"}, {28'b0, CommitFlags}, {28'b0, f});
        check({tag, "_s"},     {31'b0, CommitS},     {31'b0, s});
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        Reset      = 1'b1;
        Flush      = 1'b0;
        QueryTag   = 3'd0;
        set_app(1'b0, 1'b0, 4'd0);
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        cyc();
        cyc();
        Reset = 1'b0;
        #1;
        check("rst_tail",  {29'b0, ROBTail}, 32'd0);
        check("rst_full",  {31'b0, Full}, 32'd0);
        check("rst_qdone", {31'b0, QueryDone}, 32'd0);
        check("rst_cvalid", {31'b0, CommitValid}, 32'd0);
        check("rst_cvalue", CommitValue, 32'd0);

        // three appends, tail observed before each edge
        for (int i = 0; i < 3; i++) begin
            set_app(1'b1, 1'b0, 4'(i + 1));
            check("app_tail", {29'b0, ROBTail}, 32'(i));
            cyc();
        end
        set_app(1'b0, 1'b0, 4'd0);
        check("app3_tail",  {29'b0, ROBTail}, 32'd3);
        check("app3_count", {28'b0, dut.r_count}, 32'd3);
        check("app3_full",  {31'b0, Full}, 32'd0);

        // out-of-order completion, in-order commit
        QueryTag = 3'd1;
        set_cdb(1'b1, 3'd1, 32'h55, 4'hA);
        check("byp1_done",  {31'b0, QueryDone}, 32'd1);
        check("byp1_value", QueryValue, 32'h55);
        cyc();
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("ooo_nocommit_a", {31'b0, CommitValid}, 32'd0);
        cyc();
        check("ooo_nocommit_b", {31'b0, CommitValid}, 32'd0);
        set_cdb(1'b1, 3'd0, 32'h11, 4'h3);
        cyc();
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("head_cdb_noretire", {31'b0, CommitValid}, 32'd0);
        cyc();
        check_commit("c0", 4'd1, 32'h11, 4'h3, 1'b0);
        cyc();
        check_commit("c1", 4'd2, 32'h55, 4'hA, 1'b0);
        cyc();
        check("c2_idle", {31'b0, CommitValid}, 32'd0);

        // query on entry 2: not done, then CDB bypass, then stored
        QueryTag = 3'd2;
        #1;
        check("q2_notdone", {31'b0, QueryDone}, 32'd0);
        check("q2_zero", QueryValue, 32'd0);
        set_cdb(1'b1, 3'd2, 32'hAB, 4'h5);
        check("q2_byp_done", {31'b0, QueryDone}, 32'd1);
        check("q2_byp_value", QueryValue, 32'hAB);
        cyc();
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("q2_stored_done", {31'b0, QueryDone}, 32'd1);
        check("q2_stored_value", QueryValue, 32'hAB);
        check("q2_not_yet", {31'b0, CommitValid}, 32'd0);
        cyc();
        check_commit("c2", 4'd3, 32'hAB, 4'h5, 1'b0);

        // CDB to empty tag 5 is ignored
        QueryTag = 3'd5;
        set_cdb(1'b1, 3'd5, 32'h99, 4'hF);
        check("empty5_qdone", {31'b0, QueryDone}, 32'd0);
        cyc();
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("empty5_stored", {31'b0, QueryDone}, 32'd0);
        check("empty5_count", {28'b0, dut.r_count}, 32'd0);
        cyc();
        check("empty5_nocommit", {31'b0, CommitValid}, 32'd0);

        // fill from a clean state
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_app(1'b1, 1'b1, 4'(i + 4));
            cyc();
        end
        check("fill_full", {31'b0, Full}, 32'd1);
        check("fill_tail", {29'b0, ROBTail}, 32'd0);
        set_app(1'b1, 1'b1, 4'd15);
        cyc();
        check("ninth_tail", {29'b0, ROBTail}, 32'd0);
        check("ninth_count", {28'b0, dut.r_count}, 32'd8);
        set_app(1'b0, 1'b0, 4'd0);
        set_cdb(1'b1, 3'd0, 32'h100, 4'h0);
        cyc();
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        set_app(1'b1, 1'b1, 4'd15);
        cyc();
        set_app(1'b0, 1'b0, 4'd0);
        check_commit("full_ret", 4'd4, 32'h100, 4'h0, 1'b1);
        check("full_ret_count", {28'b0, dut.r_count}, 32'd7);
        check("full_ret_tail", {29'b0, ROBTail}, 32'd0);
        check("full_ret_notfull", {31'b0, Full}, 32'd0);

        // drain the rest, one completion per cycle
        for (int k = 1; k < 8; k++) begin
            set_cdb(1'b1, 3'(k), 32'h100 + 32'(k), 4'(k));
            cyc();
            if (k >= 2)
                check_commit("drain", 4'(k + 3), 32'h100 + 32'(k - 1), 4'(k - 1), 1'b1);
        end
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        cyc();
        check_commit("drain_last", 4'd11, 32'h107, 4'd7, 1'b1);
        check("drain_count", {28'b0, dut.r_count}, 32'd0);
        check("drain_head", {29'b0, dut.r_head}, 32'd0);

        // tags reused after wrap
        for (int i = 0; i < 3; i++) begin
            set_app(1'b1, 1'b0, 4'(i + 1));
            check("wrap_tail", {29'b0, ROBTail}, 32'(i));
            cyc();
        end
        set_app(1'b1, 1'b0, 4'd9);
        cyc();
        cyc();
        check("pre_flush_count", {28'b0, dut.r_count}, 32'd5);

        // flush with append and CDB in the same cycle
        Flush = 1'b1;
        set_cdb(1'b1, 3'd0, 32'h33, 4'h1);
        cyc();
        Flush = 1'b0;
        set_app(1'b0, 1'b0, 4'd0);
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("flush_count", {28'b0, dut.r_count}, 32'd0);
        check("flush_tail", {29'b0, ROBTail}, 32'd0);
        check("flush_cvalid", {31'b0, CommitValid}, 32'd0);
        QueryTag = 3'd0;
        #1;
        check("flush_qdone", {31'b0, QueryDone}, 32'd0);
        cyc();
        check("flush_cvalid2", {31'b0, CommitValid}, 32'd0);

        // reset with entries pending, one already done
        for (int i = 0; i < 5; i++) begin
            set_app(1'b1, 1'b1, 4'(i + 6));
            cyc();
        end
        set_app(1'b0, 1'b0, 4'd0);
        set_cdb(1'b1, 3'd1, 32'h44, 4'h2);
        cyc();
        Reset = 1'b1;
        set_app(1'b1, 1'b1, 4'd8);
        set_cdb(1'b1, 3'd0, 32'h22, 4'h6);
        cyc();
        Reset = 1'b0;
        set_app(1'b0, 1'b0, 4'd0);
        set_cdb(1'b0, 3'd0, 32'd0, 4'd0);
        check("rst2_count", {28'b0, dut.r_count}, 32'd0);
        check("rst2_tail", {29'b0, ROBTail}, 32'd0);
        check("rst2_cvalid", {31'b0, CommitValid}, 32'd0);
        check("rst2_cdest", {28'b0, CommitDest}, 32'd0);
        check("rst2_cvalue", CommitValue, 32'd0);
        check("rst2_cflags", {28'b0, CommitFlags}, 32'd0);
        check("rst2_cs", {31'b0, CommitS}, 32'd0);
        cyc();
        check("rst2_cvalid2", {31'b0, CommitValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_reorder_buffer
`default_nettype wire
